// File: rtl/jtkiwi_objscan.sv
// jtkiwi_objscan: per-scanline object scanner for the SETA-style object
// processor. Walks the Y table and attribute LUT, selects the objects that
// cover the line being rendered and issues them one at a time to the tile
// draw engine through a draw/busy handshake.
// Optional build macro JTKIWI_OBJSCAN_LIMIT_EN caps the objects issued per
// line at LIMIT; without it every matching object is issued.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CHECK | compare Y of object objcnt against the line, latch row
// ST_ATTR  | latch palette, code[15:14] and X position from the LUT
// ST_CODE  | latch flips and code[13:0] from the LUT
// ST_ISSUE | wait for the draw engine, then pulse dr_draw with payload
module jtkiwi_objscan #(
    parameter int OBJW  = 9,
    parameter int YW    = 4,
    parameter int LUTAW = 12,
    parameter int LIMIT = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             lut_cen_i,
    input  logic             hs_i,
    input  logic             flip_i,
    input  logic             page_i,
    input  logic [8:0]       vrender_i,
    output logic [OBJW-1:0]  y_addr_o,
    input  logic [7:0]       y_data_i,
    output logic [LUTAW-1:0] lut_addr_o,
    input  logic [15:0]      lut_data_i,
    output logic             dr_draw_o,
    input  logic             dr_busy_i,
    output logic [15:0]      dr_code_o,
    output logic [15:0]      dr_attr_o,
    output logic [8:0]       dr_xpos_o,
    output logic [YW-1:0]    dr_ysub_o,
    output logic             done_o,
    output logic [OBJW:0]    drawn_o
);
    typedef enum logic [1:0] {
        ST_CHECK = 2'd0,
        ST_ATTR  = 2'd1,
        ST_CODE  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    localparam logic [OBJW:0] LIMIT_M1 = (OBJW+1)'(LIMIT - 1);

    state_t          st_q;
    logic [OBJW-1:0] objcnt_q;
    logic            done_q;
    logic [OBJW:0]   drawn_q;
    logic [YW-1:0]   ysub_q;
    logic [4:0]      pal_q;
    logic [15:0]     code_q;
    logic [8:0]      xpos_q;
    logic            hflip_q;
    logic            vflip_q;
    logic            dr_draw_q;
    logic [15:0]     dr_code_q;
    logic [15:0]     dr_attr_q;
    logic [8:0]      dr_xpos_q;
    logic [YW-1:0]   dr_ysub_q;

    logic [7:0] vf;
    logic [8:0] ydiff;
    logic       match;
    logic       restart;
    logic       last_obj;
    logic       budget_en;
    logic       budget_hit;

`ifdef JTKIWI_OBJSCAN_LIMIT_EN
    assign budget_en = 1'b1;
`else
    assign budget_en = 1'b0;
`endif

    // Line compare: only the low 8 bits of the flipped line take part
    always_comb begin
        vf         = vrender_i[7:0] ^ {8{flip_i}};
        ydiff      = {1'b0, vf} - {1'b0, y_data_i};
        match      = (ydiff[8:YW] == '0);
        restart    = hs_i | (vrender_i > 9'h0F0);
        last_obj   = &objcnt_q;
        budget_hit = budget_en & (drawn_q == LIMIT_M1);
    end

    // LUT address: page on top, zero pad, then half select (attr/code) and object
    always_comb begin
        lut_addr_o           = '0;
        lut_addr_o[LUTAW-1]  = page_i;
        lut_addr_o[OBJW]     = ~st_q[1];
        lut_addr_o[OBJW-1:0] = objcnt_q;
    end

    // Scan FSM with registered draw payload; restart wins over any state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q      <= ST_CHECK;
            objcnt_q  <= '0;
            done_q    <= 1'b0;
            drawn_q   <= '0;
            ysub_q    <= '0;
            pal_q     <= '0;
            code_q    <= '0;
            xpos_q    <= '0;
            hflip_q   <= 1'b0;
            vflip_q   <= 1'b0;
            dr_draw_q <= 1'b0;
            dr_code_q <= '0;
            dr_attr_q <= '0;
            dr_xpos_q <= '0;
            dr_ysub_q <= '0;
        end else begin
            dr_draw_q <= 1'b0;
            if (restart) begin
                st_q      <= ST_CHECK;
                objcnt_q  <= '0;
                done_q    <= 1'b0;
                drawn_q   <= '0;
                dr_code_q <= '0;
                dr_attr_q <= '0;
                dr_xpos_q <= '0;
                dr_ysub_q <= '0;
            end else if (lut_cen_i && !done_q) begin
                case (st_q)
                    ST_CHECK: begin
                        ysub_q <= ydiff[YW-1:0];
                        if (match) begin
                            st_q <= ST_ATTR;
                        end else begin
                            objcnt_q <= objcnt_q + 1'b1;
                            if (last_obj) done_q <= 1'b1;
                        end
                    end
                    ST_ATTR: begin
                        {pal_q, code_q[15:14], xpos_q} <= lut_data_i;
                        st_q <= ST_CODE;
                    end
                    ST_CODE: begin
                        {hflip_q, vflip_q, code_q[13:0]} <= lut_data_i;
                        st_q <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        if (!dr_busy_i) begin
                            dr_draw_q <= 1'b1;
                            dr_code_q <= code_q;
                            dr_attr_q <= {hflip_q, vflip_q, pal_q, 9'd0};
                            dr_xpos_q <= xpos_q;
                            dr_ysub_q <= ysub_q;
                            objcnt_q  <= objcnt_q + 1'b1;
                            drawn_q   <= drawn_q + 1'b1;
                            st_q      <= ST_CHECK;
                            if (last_obj || budget_hit) done_q <= 1'b1;
                        end
                    end
                    default: st_q <= ST_CHECK;
                endcase
            end
        end
    end

    assign y_addr_o  = objcnt_q;
    assign dr_draw_o = dr_draw_q;
    assign dr_code_o = dr_code_q;
    assign dr_attr_o = dr_attr_q;
    assign dr_xpos_o = dr_xpos_q;
    assign dr_ysub_o = dr_ysub_q;
    assign done_o    = done_q;
    assign drawn_o   = drawn_q;
endmodule

// File: tb/tb_jtkiwi_objscan.sv
// Directed bench for jtkiwi_objscan: a YW=4/LIMIT=4 instance and a YW=5
// instance share the line/control inputs, each with its own table model.
module tb_jtkiwi_objscan;
    logic        clk = 1'b0;
    logic        rst_n, lut_cen, hs, flip, page;
    logic [8:0]  vrender;
    logic        busy;
    logic        busy5;

    logic [8:0]  y_addr, y_addr5;
    logic [7:0]  y_data, y_data5;
    logic [11:0] lut_addr, lut_addr5;
    logic [15:0] lut_data, lut_data5;
    logic        dr_draw, dr_draw5;
    logic [15:0] dr_code, dr_code5, dr_attr, dr_attr5;
    logic [8:0]  dr_xpos, dr_xpos5;
    logic [3:0]  dr_ysub;
    logic [4:0]  dr_ysub5;
    logic        done, done5;
    logic [9:0]  drawn, drawn5;

    logic [7:0]  ytab  [512];
    logic [7:0]  ytab5 [512];
    logic [15:0] attr_tab [512];
    logic [15:0] code_tab [512];

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;
    int pulses5 = 0;
    int base, base5, n;

    always #5 clk = ~clk;

    assign y_data    = ytab[y_addr];
    assign y_data5   = ytab5[y_addr5];
    assign lut_data  = lut_addr[9]  ? attr_tab[lut_addr[8:0]]  : code_tab[lut_addr[8:0]];
    assign lut_data5 = lut_addr5[9] ? attr_tab[lut_addr5[8:0]] : code_tab[lut_addr5[8:0]];

    jtkiwi_objscan #(.OBJW(9), .YW(4), .LUTAW(12), .LIMIT(4)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .lut_cen_i(lut_cen), .hs_i(hs),
        .flip_i(flip), .page_i(page), .vrender_i(vrender),
        .y_addr_o(y_addr), .y_data_i(y_data),
        .lut_addr_o(lut_addr), .lut_data_i(lut_data),
        .dr_draw_o(dr_draw), .dr_busy_i(busy), .dr_code_o(dr_code),
        .dr_attr_o(dr_attr), .dr_xpos_o(dr_xpos), .dr_ysub_o(dr_ysub),
        .done_o(done), .drawn_o(drawn)
    );

    jtkiwi_objscan #(.OBJW(9), .YW(5), .LUTAW(12), .LIMIT(32)) u_dut5 (
        .clk_i(clk), .rst_n_i(rst_n), .lut_cen_i(lut_cen), .hs_i(hs),
        .flip_i(flip), .page_i(page), .vrender_i(vrender),
        .y_addr_o(y_addr5), .y_data_i(y_data5),
        .lut_addr_o(lut_addr5), .lut_data_i(lut_data5),
        .dr_draw_o(dr_draw5), .dr_busy_i(busy5), .dr_code_o(dr_code5),
        .dr_attr_o(dr_attr5), .dr_xpos_o(dr_xpos5), .dr_ysub_o(dr_ysub5),
        .done_o(done5), .drawn_o(drawn5)
    );

    // Count every clock that dr_draw is seen high
    always @(negedge clk) begin
        if (dr_draw)  pulses  = pulses + 1;
        if (dr_draw5) pulses5 = pulses5 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input logic cen);
        lut_cen = cen;
        @(negedge clk);
        #1;
    endtask

    task automatic restart_scan();
        hs = 1'b1;
        step(1'b1);
        step(1'b1);
        hs = 1'b0;
    endtask

    task automatic run_done(input int max);
        int k = 0;
        while (!(done && done5) && k < max) begin
            step(1'b1);
            k++;
        end
    endtask

    initial begin
        rst_n = 1'b0; lut_cen = 1'b0; hs = 1'b1; flip = 1'b0; page = 1'b0;
        vrender = 9'h000; busy = 1'b0; busy5 = 1'b0;
        for (int i = 0; i < 512; i++) begin
            ytab[i] = 8'hFF; ytab5[i] = 8'hFF; attr_tab[i] = 16'h0; code_tab[i] = 16'h0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_draw",  {31'd0, dr_draw}, 32'd0);
        chk("rst_code",  {16'd0, dr_code}, 32'd0);
        chk("rst_attr",  {16'd0, dr_attr}, 32'd0);
        chk("rst_xpos",  {23'd0, dr_xpos}, 32'd0);
        chk("rst_ysub",  {28'd0, dr_ysub}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_drawn", {22'd0, drawn}, 32'd0);
        chk("rst_yaddr", {23'd0, y_addr}, 32'd0);
        rst_n = 1'b1;

        // single object 5 with a busy hold in ISSUE
        page = 1'b1; vrender = 9'h045;
        ytab[5] = 8'h40; attr_tab[5] = 16'h0010; code_tab[5] = 16'h8123;
        restart_scan();
        base = pulses;
        busy = 1'b1;
        repeat (18) step(1'b1);
        chk("busy_nodraw", pulses - base, 0);
        chk("busy_yaddr",  {23'd0, y_addr}, 32'd5);
        chk("busy_lutaddr", {20'd0, lut_addr}, 32'h805);
        busy = 1'b0;
        step(1'b1);
        chk("rel_draw",  pulses - base, 1);
        chk("rel_yaddr", {23'd0, y_addr}, 32'd6);
        chk("obj_xpos",  {23'd0, dr_xpos}, 32'h010);
        chk("obj_code",  {16'd0, dr_code}, 32'h0123);
        chk("obj_attr",  {16'd0, dr_attr}, 32'h8000);
        chk("obj_ysub",  {28'd0, dr_ysub}, 32'd5);
        run_done(1000);
        chk("obj_done",   {31'd0, done}, 32'd1);
        chk("obj_pulses", pulses - base, 1);
        chk("obj_drawn",  {22'd0, drawn}, 32'd1);
        chk("obj_hold",   {16'd0, dr_code}, 32'h0123);

        // restart threshold on vrender
        vrender = 9'h0F0;
        step(1'b1);
        chk("vr_f0_done", {31'd0, done}, 32'd1);
        vrender = 9'h0F1;
        step(1'b1);
        chk("vr_f1_done", {31'd0, done}, 32'd0);
        chk("vr_f1_code", {16'd0, dr_code}, 32'd0);
        chk("vr_f1_drawn", {22'd0, drawn}, 32'd0);

        // hs on the ISSUE lut_cen edge kills the issue
        vrender = 9'h045;
        restart_scan();
        base = pulses;
        busy = 1'b1;
        repeat (10) step(1'b1);
        busy = 1'b0; hs = 1'b1;
        step(1'b1);
        hs = 1'b0;
        chk("hs_nodraw", pulses - base, 0);
        chk("hs_yaddr",  {23'd0, y_addr}, 32'd0);
        chk("hs_done",   {31'd0, done}, 32'd0);
        chk("hs_drawn",  {22'd0, drawn}, 32'd0);

        // flip with 32-line objects; the 16-line instance must not match
        flip = 1'b1; vrender = 9'h0E0; page = 1'b0;
        for (int i = 0; i < 512; i++) begin ytab[i] = 8'h80; ytab5[i] = 8'h80; end
        ytab[3] = 8'h00; ytab5[3] = 8'h00; ytab5[7] = 8'h20;
        attr_tab[3] = 16'hFE55; code_tab[3] = 16'h4ABC;
        restart_scan();
        base = pulses; base5 = pulses5;
        run_done(2000);
        chk("fl_pulses5", pulses5 - base5, 1);
        chk("fl_ysub5",   {27'd0, dr_ysub5}, 32'd31);
        chk("fl_code5",   {16'd0, dr_code5}, 32'hCABC);
        chk("fl_attr5",   {16'd0, dr_attr5}, 32'h7E00);
        chk("fl_xpos5",   {23'd0, dr_xpos5}, 32'h055);
        chk("fl_drawn5",  {22'd0, drawn5}, 32'd1);
        chk("fl_drawn4",  {22'd0, drawn}, 32'd0);

        // empty line at half-rate lut_cen: done after exactly 512 lut_cen
        flip = 1'b0; vrender = 9'h045;
        for (int i = 0; i < 512; i++) ytab[i] = 8'hFF;
        restart_scan();
        n = 0;
        while (!done && n < 600) begin
            step(1'b1);
            n++;
            step(1'b0);
        end
        chk("end_count", n, 512);
        chk("end_drawn", {22'd0, drawn}, 32'd0);

        // every object matching: budget or full line
        for (int i = 0; i < 512; i++) ytab[i] = 8'h40;
        restart_scan();
        base = pulses;
        run_done(3000);
        chk("all_done", {31'd0, done}, 32'd1);
`ifdef JTKIWI_OBJSCAN_LIMIT_EN
        chk("all_pulses", pulses - base, 4);
        chk("all_drawn",  {22'd0, drawn}, 32'd4);
`else
        chk("all_pulses", pulses - base, 512);
        chk("all_drawn",  {22'd0, drawn}, 32'd512);
`endif

        // asynchronous reset mid-scan
        restart_scan();
        repeat (20) step(1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_yaddr", {23'd0, y_addr}, 32'd0);
        chk("arst_drawn", {22'd0, drawn}, 32'd0);
        chk("arst_code",  {16'd0, dr_code}, 32'd0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
